// File: rtl/la_capture_buffer.sv
// Logic-analyzer capture engine: ring-buffers samples around a masked level/edge trigger, then streams the capture oldest-first.
// Readout: first beat 2+OUTPUT_REG cycles after rd_start; reads are credit-limited by a 4-entry skid FIFO so rd_ready stalls never drop beats.
module la_capture_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int OUTPUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_en,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_len,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic                  trig_edge,
    input  logic                  rd_start,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   IC_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LAST_IDX = (ADDR_WIDTH+1)'(DEPTH-1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_READ} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, pre_cnt_q, pre_cnt_d, pre_len_l_q, pre_len_l_d;
    logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d, trig_addr_q, trig_addr_d, rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   iss_cnt_q, iss_cnt_d;
    logic                  edge_l_q, edge_l_d, prev_match_q, prev_match_d;
    logic                  triggered_q, triggered_d, done_q, done_d;
    logic                  s0_vld_q, s0_vld_d, s0_last_q, s0_last_d;
    logic [1:0]            wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [2:0]            fifo_cnt_q, fifo_cnt_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_dat_q;
    logic [DATA_WIDTH-1:0] fifo_dat [4];
    logic                  fifo_last [4];

    logic                  match, fire, wr_en, rd_issue, issue_last, pop;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [3:0]            occ;
    logic                  push, push_last, s1_inflight;
    logic [DATA_WIDTH-1:0] push_dat;

    assign busy      = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    assign done      = done_q;
    assign triggered = triggered_q;
    assign trig_addr = trig_addr_q;
    assign rd_valid  = (fifo_cnt_q != 3'd0);
    assign rd_data   = rd_valid ? fifo_dat[rd_idx_q] : '0;
    assign rd_last   = rd_valid && fifo_last[rd_idx_q];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        pre_len_l_d  = pre_len_l_q;
        post_cnt_d   = post_cnt_q;
        trig_addr_d  = trig_addr_q;
        rd_addr_d    = rd_addr_q;
        iss_cnt_d    = iss_cnt_q;
        edge_l_d     = edge_l_q;
        prev_match_d = prev_match_q;
        triggered_d  = triggered_q;
        done_d       = done_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        fifo_cnt_d   = fifo_cnt_q;
        rd_issue     = 1'b0;
        issue_addr   = rd_addr_q;
        issue_last   = 1'b0;
        match        = (((sample_in ^ trig_value) & trig_mask) == '0);
        fire         = edge_l_q ? (match && !prev_match_q) : match;
        wr_en        = busy && sample_en && !abort && !rst;
        pop          = rd_valid && rd_ready;
        occ          = {1'b0, fifo_cnt_q} + {3'b0, s0_vld_q} + {3'b0, s1_inflight};

        if (wr_en) wr_ptr_d = wr_ptr_q + A_ONE;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    wr_ptr_d     = '0;
                    pre_cnt_d    = '0;
                    pre_len_l_d  = pre_len;
                    edge_l_d     = trig_edge;
                    prev_match_d = 1'b1;
                    triggered_d  = 1'b0;
                    done_d       = 1'b0;
                    state_d      = (pre_len == '0) ? S_WAIT : S_PRE;
                end else if (state_q == S_DONE && rd_start) begin
                    // Final wr_ptr points at the oldest sample, so readout starts there.
                    state_d    = S_READ;
                    rd_issue   = 1'b1;
                    issue_addr = wr_ptr_q;
                    rd_addr_d  = wr_ptr_q + A_ONE;
                    iss_cnt_d  = IC_ONE;
                end
            end
            S_PRE: begin
                if (wr_en) begin
                    pre_cnt_d = pre_cnt_q + A_ONE;
                    if (pre_cnt_d == pre_len_l_q) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wr_en) begin
                    prev_match_d = match;
                    if (fire) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        post_cnt_d  = ~pre_len_l_q;
                        if (pre_len_l_q == '1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                if (wr_en) begin
                    post_cnt_d = post_cnt_q - A_ONE;
                    if (post_cnt_q == A_ONE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                // Only issue a read when the skid FIFO is guaranteed room for it.
                if (!iss_cnt_q[ADDR_WIDTH] && occ < 4'd4) begin
                    rd_issue   = 1'b1;
                    issue_last = (iss_cnt_q == LAST_IDX);
                    rd_addr_d  = rd_addr_q + A_ONE;
                    iss_cnt_d  = iss_cnt_q + IC_ONE;
                end
                if (pop && rd_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        s0_vld_d  = rd_issue;
        s0_last_d = issue_last;
        if (push) wr_idx_d = wr_idx_q + 2'd1;
        if (pop)  rd_idx_d = rd_idx_q + 2'd1;
        fifo_cnt_d = fifo_cnt_q + {2'b0, push} - {2'b0, pop};

        if (abort) begin
            state_d    = S_IDLE;
            done_d     = 1'b0;
            s0_vld_d   = 1'b0;
            fifo_cnt_d = '0;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic                  s1_vld_q, s1_vld_d, s1_last_q;
            logic [DATA_WIDTH-1:0] out_dat_q;
            always_comb s1_vld_d = s0_vld_q && !abort;
            always_ff @(posedge clk) begin
                if (rst) s1_vld_q <= 1'b0;
                else     s1_vld_q <= s1_vld_d;
                s1_last_q <= s0_last_q;
                if (s0_vld_q) out_dat_q <= mem_dat_q;
            end
            assign s1_inflight = s1_vld_q;
            assign push        = s1_vld_q;
            assign push_last   = s1_last_q;
            assign push_dat    = out_dat_q;
        end else begin : g_noreg
            assign s1_inflight = 1'b0;
            assign push        = s0_vld_q;
            assign push_last   = s0_last_q;
            assign push_dat    = mem_dat_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en)    mem[wr_ptr_q] <= sample_in;
        if (rd_issue) mem_dat_q <= mem[issue_addr];
        if (push) begin
            fifo_dat[wr_idx_q]  <= push_dat;
            fifo_last[wr_idx_q] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            pre_len_l_q  <= '0;
            post_cnt_q   <= '0;
            trig_addr_q  <= '0;
            rd_addr_q    <= '0;
            iss_cnt_q    <= '0;
            edge_l_q     <= 1'b0;
            prev_match_q <= 1'b1;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            s0_vld_q     <= 1'b0;
            s0_last_q    <= 1'b0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            pre_len_l_q  <= pre_len_l_d;
            post_cnt_q   <= post_cnt_d;
            trig_addr_q  <= trig_addr_d;
            rd_addr_q    <= rd_addr_d;
            iss_cnt_q    <= iss_cnt_d;
            edge_l_q     <= edge_l_d;
            prev_match_q <= prev_match_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            s0_vld_q     <= s0_vld_d;
            s0_last_q    <= s0_last_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end
endmodule

// File: tb/tb_la_capture_buffer.sv
// Bench for la_capture_buffer: two instances (OUTPUT_REG 0 and 1) share stimulus; expected beats are queued per instance at rd_start.
module tb_la_capture_buffer;
    logic       clk = 1'b0;
    logic       rst, sample_en, arm, abort, rd_start, rd_ready, trig_edge;
    logic [7:0] sample_in, trig_mask, trig_value;
    logic [3:0] pre_len;
    logic [7:0] rdd [2];
    logic       rdv [2], rdl [2], bsy [2], trg [2], dn [2];
    logic [3:0] ta  [2];

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] exq0 [$];
    logic [8:0] exq1 [$];

    always #5 clk = ~clk;

    la_capture_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_en(sample_en), .arm(arm), .abort(abort),
        .pre_len(pre_len), .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .rd_start(rd_start), .rd_data(rdd[0]), .rd_valid(rdv[0]), .rd_ready(rd_ready), .rd_last(rdl[0]),
        .trig_addr(ta[0]), .busy(bsy[0]), .triggered(trg[0]), .done(dn[0]));

    la_capture_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_en(sample_en), .arm(arm), .abort(abort),
        .pre_len(pre_len), .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .rd_start(rd_start), .rd_data(rdd[1]), .rd_valid(rdv[1]), .rd_ready(rd_ready), .rd_last(rdl[1]),
        .trig_addr(ta[1]), .busy(bsy[1]), .triggered(trg[1]), .done(dn[1]));

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v);
        sample_in = v;
        sample_en = 1'b1;
        tick();
    endtask

    task automatic stream(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) drive(8'(v));
    endtask

    task automatic do_arm(input logic [3:0] pl, input logic [7:0] m, input logic [7:0] val,
                          input logic edg, input logic [7:0] arm_sample);
        pre_len = pl; trig_mask = m; trig_value = val; trig_edge = edg;
        sample_in = arm_sample; sample_en = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic status(input string tag, input logic b, input logic t, input logic d_e, input logic [3:0] a_e);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_busy%0d", tag, d), bsy[d], b);
            chk($sformatf("%s_trig%0d", tag, d), trg[d], t);
            chk($sformatf("%s_done%0d", tag, d), dn[d], d_e);
            chk($sformatf("%s_taddr%0d", tag, d), ta[d], a_e);
        end
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready toggles. abort_after > 0 aborts once dut0 took that many beats.
    task automatic readout(input string tag, input logic [7:0] base, input int mode, input int abort_after);
        int         lat [2];
        int         beats [2];
        logic       held [2];
        logic [8:0] hold_val [2];
        logic [8:0] e;
        logic       fin;
        sample_en = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exq0.push_back({(i == 15), 8'(base + 8'(i))});
            exq1.push_back({(i == 15), 8'(base + 8'(i))});
        end
        for (int d = 0; d < 2; d++) begin
            lat[d] = -1; beats[d] = 0; held[d] = 1'b0; hold_val[d] = '0;
        end
        rd_start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            tick();
            rd_start = 1'b0;
            rd_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            for (int d = 0; d < 2; d++) begin
                if (held[d]) chk($sformatf("%s_hold%0d", tag, d), {rdl[d], rdd[d]}, hold_val[d]);
                if (rdv[d] && lat[d] < 0) begin
                    lat[d] = cyc;
                    chk($sformatf("%s_lat%0d", tag, d), cyc, 2 + d);
                end
                if (rdv[d] && rd_ready) begin
                    if ((d == 0 && exq0.size() == 0) || (d == 1 && exq1.size() == 0)) begin
                        chk($sformatf("%s_extra%0d", tag, d), 1, 0);
                    end else begin
                        e = (d == 0) ? exq0.pop_front() : exq1.pop_front();
                        chk($sformatf("%s_beat%0d_%0d", tag, d, beats[d]), {rdl[d], rdd[d]}, e);
                        beats[d]++;
                    end
                end
                held[d] = rdv[d] && !rd_ready;
                hold_val[d] = {rdl[d], rdd[d]};
            end
            if (abort_after > 0 && beats[0] >= abort_after) begin
                fin = 1'b1;
                break;
            end
            if (exq0.size() == 0 && exq1.size() == 0) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) chk({tag, "_timeout"}, 0, 1);
        tick();
        if (abort_after > 0) begin
            abort = 1'b1;
            rd_ready = 1'b0;
            tick();
            abort = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_endvalid%0d", tag, d), rdv[d], 0);
            chk($sformatf("%s_enddone%0d", tag, d), dn[d], 0);
        end
        exq0.delete();
        exq1.delete();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; arm = 1'b0; abort = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        trig_edge = 1'b0; sample_in = '0; trig_mask = '0; trig_value = '0; pre_len = '0;
        repeat (3) tick();
        status("reset", 0, 0, 0, 4'h0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_valid%0d", d), rdv[d], 0);
            chk($sformatf("reset_last%0d", d), rdl[d], 0);
            chk($sformatf("reset_data%0d", d), rdd[d], 0);
        end
        rst = 1'b0;

        // Reset asserted for 3 cycles in the middle of POST
        do_arm(4'd4, 8'hFF, 8'h20, 1'b0, 8'hA5);
        stream(0, 8'h24);
        status("midpost", 1, 1, 0, 4'h0);
        rst = 1'b1;
        stream(8'h25, 8'h27);
        rst = 1'b0;
        status("postrst", 0, 0, 0, 4'h0);
        for (int d = 0; d < 2; d++) chk($sformatf("postrst_valid%0d", d), rdv[d], 0);

        // Level trigger, continuous readout
        do_arm(4'd4, 8'hFF, 8'h20, 1'b0, 8'hA5);
        stream(0, 8'h1F);
        status("lvl_wait", 1, 0, 0, 4'h0);
        stream(8'h20, 8'h2A);
        status("lvl_post", 1, 1, 0, 4'h0);
        drive(8'h2B);
        status("lvl_done", 0, 1, 1, 4'h0);
        readout("lvl", 8'h1C, 0, 0);

        // Edge trigger: input already matching at arm must not fire
        do_arm(4'd0, 8'hFF, 8'h20, 1'b1, 8'h20);
        repeat (5) drive(8'h20);
        status("edge_hold", 1, 0, 0, 4'h0);
        drive(8'h00);
        drive(8'h20);
        status("edge_fire", 1, 1, 0, 4'h6);
        stream(8'h21, 8'h2F);
        status("edge_done", 0, 1, 1, 4'h6);
        readout("edge", 8'h20, 0, 0);

        // Backpressure, with an arm pulse during POST that must be ignored
        do_arm(4'd4, 8'hFF, 8'h20, 1'b0, 8'hA5);
        stream(0, 8'h24);
        arm = 1'b1;
        drive(8'h25);
        arm = 1'b0;
        stream(8'h26, 8'h2B);
        status("bp_done", 0, 1, 1, 4'h0);
        readout("bp", 8'h1C, 1, 0);

        // pre_len = 0 with empty mask fires on the first sample
        do_arm(4'd0, 8'h00, 8'h55, 1'b0, 8'hA5);
        stream(0, 8'h0E);
        status("pre0_post", 1, 1, 0, 4'h0);
        drive(8'h0F);
        status("pre0_done", 0, 1, 1, 4'h0);
        readout("pre0", 8'h00, 0, 0);

        // pre_len = DEPTH-1: done right after the trigger write
        do_arm(4'd15, 8'hFF, 8'h20, 1'b0, 8'hA5);
        stream(0, 8'h1F);
        status("pre15_wait", 1, 0, 0, 4'h0);
        drive(8'h20);
        status("pre15_done", 0, 1, 1, 4'h0);
        readout("pre15", 8'h11, 0, 0);

        // Abort mid-readout; rd_start in IDLE ignored; re-arm afterwards
        do_arm(4'd4, 8'hFF, 8'h20, 1'b0, 8'hA5);
        stream(0, 8'h2B);
        readout("abt", 8'h1C, 0, 5);
        status("abt_after", 0, 1, 0, 4'h0);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int d = 0; d < 2; d++) chk($sformatf("idle_rdstart%0d_%0d", d, c), rdv[d], 0);
        end
        rd_ready = 1'b0;
        do_arm(4'd2, 8'hFF, 8'h07, 1'b0, 8'hA5);
        stream(0, 8'h14);
        status("rearm_done", 0, 1, 1, 4'h7);
        readout("rearm", 8'h05, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
